// File: rtl/lift_row_seq.sv
`default_nettype none
// ============================================================================
// Module   : lift_row_seq
// Brief    : Row sequencer for the 5/3 lifting datapath. Walks one row held
//            in a dual-port buffer, presents left/centre/right operands to
//            the lifting core and writes each result back in place. One
//            start/done transaction performs a full forward or inverse
//            1-D pass (two half-passes: odd/even or even/odd).
// Revision : 1.0 - initial release
// ============================================================================
module lift_row_seq #(
    parameter int WIDTH    = 16,
    parameter int DEPTH    = 64,
    parameter int ADDR_W   = $clog2(DEPTH),
    parameter int LIFT_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              fwd,
    input  logic [ADDR_W:0]   len,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [WIDTH-1:0]  rd_data,
    output logic              wr_dv,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [WIDTH-1:0]  wr_data,
    output logic [WIDTH-1:0]  l_s,
    output logic [WIDTH-1:0]  s_s,
    output logic [WIDTH-1:0]  r_s,
    output logic              e_o_s,
    output logic              f_i_s,
    input  logic [WIDTH-1:0]  res_s
);

    localparam int                c_LAT_W    = (LIFT_LAT > 1) ? $clog2(LIFT_LAT) : 1;
    localparam logic [c_LAT_W-1:0] c_LAT_LAST = c_LAT_W'(LIFT_LAT - 1);
    localparam logic [ADDR_W:0]   c_DEPTH    = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0]   c_ONE      = (ADDR_W+1)'(1);
    localparam logic [ADDR_W:0]   c_TWO      = (ADDR_W+1)'(2);
    localparam logic [ADDR_W-1:0] c_ADDR_ONE = ADDR_W'(1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RD_L = 3'd1,
        S_RD_S = 3'd2,
        S_RD_R = 3'd3,
        S_CAP  = 3'd4,
        S_EXEC = 3'd5,
        S_WR   = 3'd6,
        S_DONE = 3'd7
    } state_t;

    state_t              r_state;
    logic [ADDR_W:0]     r_len;
    logic [ADDR_W-1:0]   r_idx;
    logic                r_pass;   // 0 = first half-pass, 1 = second
    logic                r_odd;    // current half-pass walks odd indices
    logic [c_LAT_W-1:0]  r_lat;

    logic                w_len_ok;
    logic [ADDR_W:0]     w_len_m1;
    logic [ADDR_W:0]     w_len_m2;
    logic [ADDR_W:0]     w_next_idx;
    logic                w_pass_end;
    logic [ADDR_W-1:0]   w_r_addr;

    // Length validity, symmetric-extension right address and pass-end test
    assign w_len_ok   = ~len[0] && (len >= c_TWO) && (len <= c_DEPTH);
    assign w_len_m1   = r_len - c_ONE;
    assign w_len_m2   = r_len - c_TWO;
    assign w_next_idx = {1'b0, r_idx} + c_TWO;
    assign w_pass_end = (w_next_idx >= r_len);
    assign w_r_addr   = ({1'b0, r_idx} == w_len_m1) ? w_len_m2[ADDR_W-1:0]
                                                    : r_idx + c_ADDR_ONE;

    // Write data is the core result as seen during the WR cycle itself
    assign wr_data = wr_dv ? res_s : '0;

    // Sequencer FSM with registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_len   <= '0;
            r_idx   <= '0;
            r_pass  <= 1'b0;
            r_odd   <= 1'b0;
            r_lat   <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;
            rd_en   <= 1'b0;
            rd_addr <= '0;
            wr_dv   <= 1'b0;
            wr_addr <= '0;
            l_s     <= '0;
            s_s     <= '0;
            r_s     <= '0;
            e_o_s   <= 1'b0;
            f_i_s   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    done <= 1'b0;
                    err  <= 1'b0;
                    if (start) begin
                        if (w_len_ok) begin
                            // Forward starts with the odd (predict) half-pass
                            r_len   <= len;
                            f_i_s   <= fwd;
                            r_odd   <= fwd;
                            e_o_s   <= ~fwd;
                            r_pass  <= 1'b0;
                            r_idx   <= fwd ? c_ADDR_ONE : '0;
                            rd_addr <= fwd ? '0 : c_ADDR_ONE;
                            rd_en   <= 1'b1;
                            busy    <= 1'b1;
                            r_state <= S_RD_L;
                        end else begin
                            done    <= 1'b1;
                            err     <= 1'b1;
                            r_state <= S_DONE;
                        end
                    end
                end
                S_RD_L: begin
                    rd_addr <= r_idx;
                    r_state <= S_RD_S;
                end
                S_RD_S: begin
                    l_s     <= rd_data;
                    rd_addr <= w_r_addr;
                    r_state <= S_RD_R;
                end
                S_RD_R: begin
                    s_s     <= rd_data;
                    rd_en   <= 1'b0;
                    r_state <= S_CAP;
                end
                S_CAP: begin
                    r_s     <= rd_data;
                    r_lat   <= '0;
                    r_state <= S_EXEC;
                end
                S_EXEC: begin
                    if (r_lat == c_LAT_LAST) begin
                        wr_dv   <= 1'b1;
                        wr_addr <= r_idx;
                        r_state <= S_WR;
                    end else begin
                        r_lat <= r_lat + 1'b1;
                    end
                end
                S_WR: begin
                    wr_dv <= 1'b0;
                    if (!w_pass_end) begin
                        // Left neighbour of i+2 is i+1
                        r_idx   <= w_next_idx[ADDR_W-1:0];
                        rd_addr <= r_idx + c_ADDR_ONE;
                        rd_en   <= 1'b1;
                        r_state <= S_RD_L;
                    end else if (!r_pass) begin
                        // Switch parity; new first index is 1 (odd) or 0 (even)
                        r_pass  <= 1'b1;
                        r_odd   <= ~r_odd;
                        e_o_s   <= r_odd;
                        r_idx   <= r_odd ? '0 : c_ADDR_ONE;
                        rd_addr <= r_odd ? c_ADDR_ONE : '0;
                        rd_en   <= 1'b1;
                        r_state <= S_RD_L;
                    end else begin
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    done    <= 1'b0;
                    err     <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_lift_row_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_lift_row_seq
// Brief    : Self-checking bench for lift_row_seq with a buffer model, a
//            lifting-core model and a row-level reference transform.
// Revision : 1.0 - initial release
// ============================================================================
module tb_lift_row_seq;

    localparam int WIDTH = 16;
    localparam int DEPTH = 64;
    localparam int ADDR_W = 6;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic              fwd;
    logic [ADDR_W:0]   len;
    logic              busy, done, err, rd_en, wr_dv, e_o_s, f_i_s;
    logic [ADDR_W-1:0] rd_addr, wr_addr;
    logic [WIDTH-1:0]  rd_data, wr_data, l_s, s_s, r_s, res_s;

    lift_row_seq #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .LIFT_LAT(1)) dut (
        .clk(clk), .rst(rst), .start(start), .fwd(fwd), .len(len),
        .busy(busy), .done(done), .err(err),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
        .wr_dv(wr_dv), .wr_addr(wr_addr), .wr_data(wr_data),
        .l_s(l_s), .s_s(s_s), .r_s(r_s), .e_o_s(e_o_s), .f_i_s(f_i_s),
        .res_s(res_s)
    );

    always #5 clk = ~clk;

    // ---------------- buffer model (1-cycle read latency) -------------------
    logic [WIDTH-1:0]  mem [DEPTH];
    logic              ld_en;
    logic [ADDR_W-1:0] ld_addr;
    logic [WIDTH-1:0]  ld_data;

    always @(posedge clk) begin
        if (ld_en) mem[ld_addr] <= ld_data;
        else if (wr_dv) mem[wr_addr] <= wr_data;
        if (rd_en) rd_data <= mem[rd_addr];
    end

    // ---------------- lifting core model (1-cycle latency) ------------------
    function automatic logic [WIDTH-1:0] core(input logic [WIDTH-1:0] l, input logic [WIDTH-1:0] s,
                                              input logic [WIDTH-1:0] r, input logic upd, input logic f);
        int li, si, ri, d, v;
        li = int'($signed(l)); si = int'($signed(s)); ri = int'($signed(r));
        if (upd) begin
            d = (li + ri + 2) >>> 2;
            v = f ? si + d : si - d;
        end else begin
            d = (li + ri) >>> 1;
            v = f ? si - d : si + d;
        end
        return v[WIDTH-1:0];
    endfunction

    always @(posedge clk) res_s <= core(l_s, s_s, r_s, e_o_s, f_i_s);

    // ---------------- activity monitor --------------------------------------
    int rd_cnt = 0, wr_cnt = 0, ovl_cnt = 0, done_cnt = 0;
    int wlog[$];

    always @(posedge clk) begin
        if (rd_en) rd_cnt++;
        if (wr_dv) begin
            wr_cnt++;
            wlog.push_back(int'(wr_addr));
        end
        if (rd_en && wr_dv) ovl_cnt++;
        if (done) done_cnt++;
    end

    // ---------------- checking ----------------------------------------------
    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // ---------------- row-level reference -----------------------------------
    int refm [DEPTH];
    int ref_ord[$];

    function automatic int wrap(input int v);
        logic [WIDTH-1:0] t;
        t = v[WIDTH-1:0];
        return int'($signed(t));
    endfunction

    task automatic ref_run(input bit f, input int n);
        int l, r, s, d;
        bit odd;
        ref_ord.delete();
        for (int p = 0; p < 2; p++) begin
            odd = (p == 0) ? f : !f;
            for (int i = (odd ? 1 : 0); i < n; i += 2) begin
                l = (i == 0) ? refm[1] : refm[i-1];
                r = (i == n-1) ? refm[n-2] : refm[i+1];
                s = refm[i];
                if (odd) begin
                    d = (l + r) >>> 1;
                    refm[i] = wrap(f ? s - d : s + d);
                end else begin
                    d = (l + r + 2) >>> 2;
                    refm[i] = wrap(f ? s + d : s - d);
                end
                ref_ord.push_back(i);
            end
        end
    endtask

    // ---------------- drivers -----------------------------------------------
    task automatic load_word(input int a, input int v);
        @(negedge clk);
        ld_en = 1'b1; ld_addr = a[ADDR_W-1:0]; ld_data = v[WIDTH-1:0];
        @(negedge clk);
        ld_en = 1'b0;
    endtask

    // Launch a pass and wait for done; lat = 1 in the cycle right after the start edge
    task automatic run(input bit f, input int n, input bit disturb, output int lat, output bit e, output bit b);
        int t;
        @(negedge clk);
        fwd = f; len = n[ADDR_W:0]; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        t = 1;
        lat = -1; e = 1'b0; b = 1'b1;
        while (t < 3000) begin
            if (disturb && t == 5) begin start = 1'b1; fwd = !f; len = 7'd5; end
            if (disturb && t == 6) begin start = 1'b0; fwd = f; len = n[ADDR_W:0]; end
            if (done) begin
                lat = t; e = err; b = busy;
                break;
            end
            @(negedge clk);
            t++;
        end
        if (lat < 0) begin
            failures++;
            $display("FAIL done_timeout actual=none expected=done");
        end
    endtask

    // ---------------- directed vector table ---------------------------------
    typedef struct {
        bit               f;
        int               n;
        logic [3:0][15:0] init;
        logic [3:0][15:0] exp;
        logic [3:0][7:0]  ord;
        int               nw;
        int               lat;
        bit               e;
    } vec_t;

    function automatic logic [3:0][15:0] w4(input int a, input int b, input int c, input int d);
        logic [3:0][15:0] v;
        v[0] = a[15:0]; v[1] = b[15:0]; v[2] = c[15:0]; v[3] = d[15:0];
        return v;
    endfunction

    function automatic logic [3:0][7:0] o4(input int a, input int b, input int c, input int d);
        logic [3:0][7:0] v;
        v[0] = a[7:0]; v[1] = b[7:0]; v[2] = c[7:0]; v[3] = d[7:0];
        return v;
    endfunction

    vec_t tbl [5];

    initial begin
        int lat, rb, wb, wl, dc, n;
        bit e, b, f;

        tbl[0] = '{f:1'b1, n:4, init:w4(215,216,217,218), exp:w4(215,0,217,1),   ord:o4(1,3,0,2), nw:4, lat:25, e:1'b0};
        tbl[1] = '{f:1'b0, n:4, init:w4(215,0,217,1),     exp:w4(215,216,217,218), ord:o4(0,2,1,3), nw:4, lat:25, e:1'b0};
        tbl[2] = '{f:1'b1, n:2, init:w4(215,217,0,0),     exp:w4(216,2,0,0),     ord:o4(1,0,0,0), nw:2, lat:13, e:1'b0};
        tbl[3] = '{f:1'b1, n:3, init:w4(11,22,33,44),     exp:w4(11,22,33,44),   ord:o4(0,0,0,0), nw:0, lat:1,  e:1'b1};
        tbl[4] = '{f:1'b0, n:0, init:w4(5,6,7,8),         exp:w4(5,6,7,8),       ord:o4(0,0,0,0), nw:0, lat:1,  e:1'b1};

        rst = 1'b1; start = 1'b0; fwd = 1'b0; len = '0;
        ld_en = 1'b0; ld_addr = '0; ld_data = '0;
        repeat (3) @(negedge clk);
        chk("reset_ctrl", int'({busy, done, err, rd_en, wr_dv, e_o_s, f_i_s}), 0);
        chk("reset_addr", int'({rd_addr, wr_addr}), 0);
        chk("reset_ops", int'(l_s) + int'(s_s) + int'(r_s) + int'(wr_data), 0);
        rst = 1'b0;

        // Table-driven directed vectors
        for (int v = 0; v < 5; v++) begin
            for (int i = 0; i < 4; i++) load_word(i, int'(tbl[v].init[i]));
            rb = rd_cnt; wb = wr_cnt; wl = wlog.size();
            run(tbl[v].f, tbl[v].n, 1'b0, lat, e, b);
            chk($sformatf("v%0d_latency", v), lat, tbl[v].lat);
            chk($sformatf("v%0d_err", v), int'(e), int'(tbl[v].e));
            chk($sformatf("v%0d_busy_at_done", v), int'(b), 0);
            chk($sformatf("v%0d_writes", v), wr_cnt - wb, tbl[v].nw);
            if (tbl[v].e) chk($sformatf("v%0d_reads", v), rd_cnt - rb, 0);
            else          chk($sformatf("v%0d_reads", v), rd_cnt - rb, 3 * tbl[v].n);
            for (int i = 0; i < tbl[v].nw && wl + i < wlog.size(); i++)
                chk($sformatf("v%0d_worder%0d", v, i), wlog[wl+i], int'(tbl[v].ord[i]));
            repeat (2) @(negedge clk);
            for (int i = 0; i < 4; i++)
                chk($sformatf("v%0d_mem%0d", v, i), int'(mem[i]), int'(tbl[v].exp[i]));
        end

        // Disturbed run: start/fwd/len wiggled mid-pass must not matter
        for (int i = 0; i < 4; i++) load_word(i, int'(tbl[0].init[i]));
        run(1'b1, 4, 1'b1, lat, e, b);
        chk("dist_latency", lat, 25);
        repeat (2) @(negedge clk);
        for (int i = 0; i < 4; i++) chk($sformatf("dist_mem%0d", i), int'(mem[i]), int'(tbl[0].exp[i]));

        // Randomized rows against the reference transform
        for (int it = 0; it < 8; it++) begin
            n = 2 * int'($urandom_range(1, 16));
            f = 1'($urandom_range(0, 1));
            for (int i = 0; i < n; i++) begin
                refm[i] = int'($urandom_range(0, 4000)) - 2000;
                load_word(i, refm[i]);
            end
            ref_run(f, n);
            wl = wlog.size();
            run(f, n, 1'b0, lat, e, b);
            chk($sformatf("rnd%0d_latency", it), lat, 1 + 6 * n);
            chk($sformatf("rnd%0d_err", it), int'(e), 0);
            chk($sformatf("rnd%0d_nwrites", it), wlog.size() - wl, ref_ord.size());
            for (int i = 0; i < ref_ord.size() && wl + i < wlog.size(); i++)
                if (wlog[wl+i] != ref_ord[i]) chk($sformatf("rnd%0d_worder%0d", it, i), wlog[wl+i], ref_ord[i]);
            repeat (2) @(negedge clk);
            for (int i = 0; i < n; i++)
                chk($sformatf("rnd%0d_mem%0d", it, i), int'($signed(mem[i])), refm[i]);
        end

        // Reset during the second WR of a len=8 pass
        for (int i = 0; i < 8; i++) load_word(i, 100 + 7 * i);
        wb = wr_cnt; dc = done_cnt;
        @(negedge clk);
        fwd = 1'b1; len = 7'd8; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int t = 0; t < 200; t++) begin
            if (wr_dv && wr_cnt == wb + 1) break;
            @(negedge clk);
        end
        chk("rst_reached_wr2", int'(wr_dv && wr_cnt == wb + 1), 1);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_ctrl", int'({busy, done, err, rd_en, wr_dv, e_o_s, f_i_s}), 0);
        chk("rst_addr", int'({rd_addr, wr_addr}), 0);
        chk("rst_ops", int'(l_s) + int'(s_s) + int'(r_s) + int'(wr_data), 0);
        rst = 1'b0;
        rb = rd_cnt;
        repeat (30) @(negedge clk);
        chk("rst_no_writes_after", wr_cnt - wb, 2);
        chk("rst_no_reads_after", rd_cnt - rb, 0);
        chk("rst_no_done", done_cnt - dc, 0);

        // Fresh start after reset
        for (int i = 0; i < 8; i++) begin
            refm[i] = int'($urandom_range(0, 600)) - 300;
            load_word(i, refm[i]);
        end
        ref_run(1'b0, 8);
        run(1'b0, 8, 1'b0, lat, e, b);
        chk("post_rst_latency", lat, 49);
        repeat (2) @(negedge clk);
        for (int i = 0; i < 8; i++)
            chk($sformatf("post_rst_mem%0d", i), int'($signed(mem[i])), refm[i]);

        chk("rd_wr_overlap", ovl_cnt, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
